// File: rtl/simd_alu_pkg.sv
// Shared types and helpers for the SIMD adder/subtractor pipeline.
// Op encoding, per-lane flag bundle and signed saturation bounds.
package simd_alu_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        SUB  = 2'b01,
        ADDS = 2'b10,
        SUBS = 2'b11
    } add_op_t;

    typedef struct packed {
        logic N;
        logic Z;
        logic C;
        logic V;
    } alu_flags_t;

    localparam int unsigned SAT_FN_W = 64;

    // Largest positive two's-complement value of the given width, zero-extended.
    function automatic logic [SAT_FN_W-1:0] lane_sat_max(input int unsigned width);
        return (SAT_FN_W'(1) << (width - 1)) - SAT_FN_W'(1);
    endfunction

    function automatic logic [SAT_FN_W-1:0] lane_sat_min(input int unsigned width);
        return SAT_FN_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/simd_adder_pipe_if.sv
// Operand/result bundle with valid/ready handshakes on both sides.
// The master drives operands and out_ready; the slave is the adder pipeline.
interface simd_adder_pipe_if
    import simd_alu_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 32
);
    logic                    in_valid;
    logic                    in_ready;
    add_op_t                 op;
    logic                    C_in;
    logic [LANES*LANE_W-1:0] A;
    logic [LANES*LANE_W-1:0] B;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*LANE_W-1:0] R;
    logic [LANES-1:0]        N_flag;
    logic [LANES-1:0]        Z_flag;
    logic [LANES-1:0]        C_flag;
    logic [LANES-1:0]        V_flag;

    modport master (
        output in_valid, op, C_in, A, B, out_ready,
        input  in_ready, out_valid, R, N_flag, Z_flag, C_flag, V_flag
    );

    modport slave (
        input  in_valid, op, C_in, A, B, out_ready,
        output in_ready, out_valid, R, N_flag, Z_flag, C_flag, V_flag
    );
endinterface

// File: rtl/simd_adder_pipe_lane.sv
// One lane of the SIMD adder: low half sum in stage 1, high half, flags
// and saturation in stage 2. Load enables come from the shared pipeline control.
module lane_add_pipe
    import simd_alu_pkg::*;
#(
    parameter int unsigned LANE_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld1_i,
    input  logic              ld2_i,
    input  add_op_t           op_i,
    input  logic              c_in_i,
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    output logic [LANE_W-1:0] r_o,
    output alu_flags_t        flags_o
);
    localparam int unsigned H = LANE_W / 2;
    localparam logic [LANE_W-1:0] SAT_MAX = LANE_W'(lane_sat_max(LANE_W));
    localparam logic [LANE_W-1:0] SAT_MIN = LANE_W'(lane_sat_min(LANE_W));

    logic              is_add;
    logic [LANE_W-1:0] bx;
    logic              cin;
    logic [H:0]        sum_lo;

    logic [H-1:0] lo_q, lo_d;
    logic         c_mid_q, c_mid_d;
    logic [H-1:0] a_hi_q, a_hi_d;
    logic [H-1:0] bx_hi_q, bx_hi_d;
    add_op_t      op_q, op_d;

    logic [H:0]        sum_hi;
    logic [LANE_W-1:0] raw;
    logic              ovf;
    logic              sat_op;

    logic [LANE_W-1:0] r_q, r_d;
    alu_flags_t        flags_q, flags_d;

    // Subtraction is A + ~B + 1; carry-in only matters for the add ops.
    always_comb begin
        is_add  = (op_i == ADD) || (op_i == ADDS);
        bx      = is_add ? b_i : ~b_i;
        cin     = is_add ? c_in_i : 1'b1;
        sum_lo  = {1'b0, a_i[H-1:0]} + {1'b0, bx[H-1:0]} + {{H{1'b0}}, cin};
        lo_d    = sum_lo[H-1:0];
        c_mid_d = sum_lo[H];
        a_hi_d  = a_i[LANE_W-1:H];
        bx_hi_d = bx[LANE_W-1:H];
        op_d    = op_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q    <= '0;
            c_mid_q <= 1'b0;
            a_hi_q  <= '0;
            bx_hi_q <= '0;
            op_q    <= ADD;
        end else if (ld1_i) begin
            lo_q    <= lo_d;
            c_mid_q <= c_mid_d;
            a_hi_q  <= a_hi_d;
            bx_hi_q <= bx_hi_d;
            op_q    <= op_d;
        end
    end

    // C and V always describe the raw sum; N and Z describe the delivered result.
    always_comb begin
        sum_hi    = {1'b0, a_hi_q} + {1'b0, bx_hi_q} + {{H{1'b0}}, c_mid_q};
        raw       = {sum_hi[H-1:0], lo_q};
        ovf       = (a_hi_q[H-1] == bx_hi_q[H-1]) && (raw[LANE_W-1] != a_hi_q[H-1]);
        sat_op    = (op_q == ADDS) || (op_q == SUBS);
        r_d       = (sat_op && ovf) ? (a_hi_q[H-1] ? SAT_MIN : SAT_MAX) : raw;
        flags_d   = '0;
        flags_d.N = r_d[LANE_W-1];
        flags_d.Z = (r_d == '0);
        flags_d.C = sum_hi[H];
        flags_d.V = ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            flags_q <= '0;
        end else if (ld2_i) begin
            r_q     <= r_d;
            flags_q <= flags_d;
        end
    end

    assign r_o     = r_q;
    assign flags_o = flags_q;

endmodule

// File: rtl/simd_adder_pipe.sv
// Two-stage SIMD add/sub pipeline: LANES independent lanes plus the shared
// valid/ready control that stalls both stages together from the output side.
module simd_adder_pipe
    import simd_alu_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    simd_adder_pipe_if.slave bus
);
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic adv1, adv2;
    logic ld1, ld2;

    logic [LANES*LANE_W-1:0] r_all;
    alu_flags_t              flags_all [LANES];
    logic [LANES-1:0]        n_all, z_all, c_all, v_all;

    // in_ready depends only on stage occupancy and out_ready, never on in_valid.
    always_comb begin
        adv2       = !s2_valid_q || bus.out_ready;
        adv1       = !s1_valid_q || adv2;
        ld1        = adv1 && bus.in_valid;
        ld2        = adv2 && s1_valid_q;
        s1_valid_d = adv1 ? bus.in_valid : s1_valid_q;
        s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        lane_add_pipe #(
            .LANE_W (LANE_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .ld1_i   (ld1),
            .ld2_i   (ld2),
            .op_i    (bus.op),
            .c_in_i  (bus.C_in),
            .a_i     (bus.A[i*LANE_W +: LANE_W]),
            .b_i     (bus.B[i*LANE_W +: LANE_W]),
            .r_o     (r_all[i*LANE_W +: LANE_W]),
            .flags_o (flags_all[i])
        );
    end

    always_comb begin
        n_all = '0;
        z_all = '0;
        c_all = '0;
        v_all = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            n_all[i] = flags_all[i].N;
            z_all[i] = flags_all[i].Z;
            c_all[i] = flags_all[i].C;
            v_all[i] = flags_all[i].V;
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.R         = r_all;
    assign bus.N_flag    = n_all;
    assign bus.Z_flag    = z_all;
    assign bus.C_flag    = c_all;
    assign bus.V_flag    = v_all;

endmodule
